sdpram_bist_ctrl: RTL



---
 rtl/sdpram_bist_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sdpram_bist_ctrl.sv
// sdpram_bist_ctrl
// Self-checking traffic generator for a simple dual-port RAM. Each run writes
// a selectable pattern to every address, reads every address back and
// compares the read data against a regenerated expectation. It can repeat
// this write/read sequence for several passes, inverting the pattern on odd
// passes.
//
// Ports
//   wr_clk          single clock for controller and both RAM ports
//   tb_wr_rst       asynchronous active-high reset
//   start           run request, only looked at while idle
//   mode[1:0]       pattern select, captured when start is accepted
//   busy            high from the cycle after acceptance through DONE
//   done            one-cycle pulse at the end of a run
//   pass            result of the last run, held until the next run starts
//   err_cnt         saturating mismatch count
//   first_err_addr  address of the first mismatch of the run
//   ram_wr_*        RAM write port (enable, address, data)
//   ram_rd_en/addr  RAM read request
//   ram_rd_data     RAM read data, RD_LATENCY cycles after the read address
module sdpram_bist_ctrl #(
  parameter int ADDR_WIDTH    = 13,
  parameter int DATA_WIDTH    = 14,
  parameter int RD_LATENCY    = 1,
  parameter int PASSES        = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     wr_clk,
  input  logic                     tb_wr_rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic                     ram_wr_en,
  output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_wr_data,
  output logic                     ram_rd_en,
  output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr;       // address counter, reused as drain counter
  logic [4:0]              pidx;       // pass index, PASSES is at most 16
  logic [1:0]              mode_q;
  logic                    pass_q;
  logic                    start_acc;
  logic                    next_pass;

  logic [RD_LATENCY-1:0]   vld_p;
  logic [ADDR_WIDTH-1:0]   addr_p [RD_LATENCY];
  logic                    cmp_vld;
  logic [ADDR_WIDTH-1:0]   cmp_addr;
  logic                    mismatch;

  // Pattern for address a; inv flips the whole word on odd passes.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [1:0]            m,
    input logic                  inv
  );
    logic [DATA_WIDTH-1:0] av;
    logic [DATA_WIDTH-1:0] alt;
    logic [DATA_WIDTH-1:0] v;
    av = DATA_WIDTH'(a);
    // Even address: 0101.. (bit 0 set); odd address: 1010..
    for (int i = 0; i < DATA_WIDTH; i++) begin
      alt[i] = ((i % 2) == 1) ? a[0] : ~a[0];
    end
    case (m)
      2'd0:    v = '1 - av;
      2'd1:    v = av;
      2'd2:    v = alt;
      default: v = ~alt;
    endcase
    return inv ? ~v : v;
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
    input logic [ERR_CNT_WIDTH-1:0] c
  );
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n     = state;
    busy        = 1'b1;
    done        = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    start_acc   = 1'b0;
    next_pass   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_n   = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = addr;
        ram_wr_data = pattern(addr, mode_q, pidx[0]);
        if (addr == '1) state_n = S_GAP;
      end
      S_GAP: state_n = S_READ;
      S_READ: begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = addr;
        if (addr == '1) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (addr == ADDR_WIDTH'(RD_LATENCY - 1)) begin
          if (pidx < 5'(PASSES - 1)) begin
            next_pass = 1'b1;
            state_n   = S_WRITE;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // In DONE the final compare has already landed in err_cnt.
  assign pass = (state == S_DONE) ? (err_cnt == '0) : pass_q;

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      addr           <= '0;
      pidx           <= '0;
      mode_q         <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass_q         <= 1'b0;
    end else begin
      if (state_n != state) begin
        addr <= '0;
      end else if (state == S_WRITE || state == S_READ || state == S_DRAIN) begin
        addr <= addr + 1'b1;
      end
      if (start_acc) begin
        mode_q         <= mode;
        pidx           <= '0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        pass_q         <= 1'b0;
      end else begin
        if (next_pass) pidx <= pidx + 1'b1;
        if (mismatch) begin
          err_cnt <= sat_inc(err_cnt);
          if (err_cnt == '0) first_err_addr <= cmp_addr;
        end
        if (state == S_DONE) pass_q <= (err_cnt == '0);
      end
    end
  end

  // ---- stage p0..p(RD_LATENCY-1): read request travels with the RAM latency
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= ram_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge wr_clk) begin
    addr_p[0] <= ram_rd_addr;
    for (int i = 1; i < RD_LATENCY; i++) addr_p[i] <= addr_p[i-1];
  end

  // ---- compare stage: read data aligned with the delayed address
  assign cmp_vld  = vld_p[RD_LATENCY-1];
  assign cmp_addr = addr_p[RD_LATENCY-1];
  assign mismatch = cmp_vld && (ram_rd_data != pattern(cmp_addr, mode_q, pidx[0]));

endmodule
